dl_reset_sequencer: RTL

//  Sequences HPS ioctl download traffic into the arcade core: routes ROM bytes to the core's dn_* port,

---
 rtl/dl_reset_sequencer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/dl_reset_sequencer.sv
// dl_reset_sequencer
//   Sits between hps_io and the arcade core. It steers HPS ioctl download
//   traffic into the core:
//     - index 0 bytes go to the ROM download port (rom_*),
//     - index 1 bytes are latched as the game-variant id (mod_id),
//     - index 254 bytes are latched into the DIP switch bank (dipsw).
//   The core is held in reset (core_reset) while any download is active and
//   for a fixed settle time after the download ends or a user reset drops.
//
// Optional feature: define DL_CHECKSUM_EN to add rom_sum/sum_valid, a
// running mod-256 sum of accepted ROM bytes for the current download.
//
// Ports
//   clk             system clock (clk_sys)
//   reset           synchronous, active-high reset
//   ioctl_download  HPS download window active
//   ioctl_index     0 = ROM, 1 = mod select, 254 = DIP
//   ioctl_wr        one-clock write strobe
//   ioctl_addr      byte address
//   ioctl_dout      byte data
//   user_reset      menu/button reset request (level)
//   rom_wr          write strobe to core dn_wr, one clock after ioctl_wr
//   rom_addr        registered address to core dn_addr
//   rom_data        registered data to core dn_data
//   mod_id          latched variant byte
//   dipsw           DIP byte k at [8k+7:8k]
//   core_reset      reset to core
//   cfg_valid       high once a ROM download has completed since reset
//   rom_sum         (DL_CHECKSUM_EN) mod-256 sum of accepted ROM bytes
//   sum_valid       (DL_CHECKSUM_EN) rom_sum is final for the last download
module dl_reset_sequencer #(
  parameter int ROM_AW    = 16,
  parameter int RST_HOLD  = 64,
  parameter int DIP_BYTES = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ioctl_download,
  input  logic [7:0]             ioctl_index,
  input  logic                   ioctl_wr,
  input  logic [24:0]            ioctl_addr,
  input  logic [7:0]             ioctl_dout,
  input  logic                   user_reset,
  output logic                   rom_wr,
  output logic [ROM_AW-1:0]      rom_addr,
  output logic [7:0]             rom_data,
  output logic [7:0]             mod_id,
  output logic [8*DIP_BYTES-1:0] dipsw,
  output logic                   core_reset,
`ifdef DL_CHECKSUM_EN
  output logic [7:0]             rom_sum,
  output logic                   sum_valid,
`endif
  output logic                   cfg_valid
);

  localparam int CW = (RST_HOLD > 2) ? $clog2(RST_HOLD) : 1;
  localparam logic [CW-1:0] HOLD_INIT = CW'(RST_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SETTLE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          rom_seen;
  logic          rom_hit;
  logic          mod_hit;
  logic          dip_hit;

  // Write decode is independent of state: the HPS may strobe ioctl_wr on the
  // same clock that ioctl_download rises, so nothing is gated by the FSM.
  assign rom_hit = ioctl_wr && (ioctl_index == 8'd0) &&
                   ((ioctl_addr >> ROM_AW) == 25'd0);
  assign mod_hit = ioctl_wr && (ioctl_index == 8'd1);
  assign dip_hit = ioctl_wr && (ioctl_index == 8'd254);

  // user_reset is ORed in so the core is held from the very first clock the
  // request is seen; the FSM then takes over and guarantees the settle time.
  assign core_reset = (state != IDLE) || user_reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SETTLE;
      cnt   <= HOLD_INIT;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (ioctl_download) begin
          state_next = LOAD;
        end else if (user_reset) begin
          state_next = SETTLE;
          cnt_next   = HOLD_INIT;
        end
      end
      LOAD: begin
        if (!ioctl_download) begin
          state_next = SETTLE;
          cnt_next   = HOLD_INIT;
        end
      end
      SETTLE: begin
        // A held user_reset keeps reloading so the settle time is measured
        // from the clock it finally drops.
        if (ioctl_download) begin
          state_next = LOAD;
        end else if (user_reset) begin
          cnt_next = HOLD_INIT;
        end else if (cnt == '0) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt - CW'(1);
        end
      end
      default: begin
        state_next = SETTLE;
        cnt_next   = HOLD_INIT;
      end
    endcase
  end

  // rom_seen remembers whether index 0 appeared during the current download
  // window; it qualifies cfg_valid when the window closes.
  always_ff @(posedge clk) begin
    if (reset) begin
      rom_wr    <= 1'b0;
      rom_addr  <= '0;
      rom_data  <= 8'd0;
      mod_id    <= 8'd0;
      dipsw     <= '1;
      cfg_valid <= 1'b0;
      rom_seen  <= 1'b0;
    end else begin
      rom_wr <= rom_hit;
      if (rom_hit) begin
        rom_addr <= ioctl_addr[ROM_AW-1:0];
        rom_data <= ioctl_dout;
      end
      if (mod_hit) begin
        mod_id <= ioctl_dout;
      end
      for (int k = 0; k < DIP_BYTES; k++) begin
        if (dip_hit && (ioctl_addr == 25'(k))) begin
          dipsw[8*k +: 8] <= ioctl_dout;
        end
      end
      if (!ioctl_download) begin
        rom_seen <= 1'b0;
      end else if (ioctl_index == 8'd0) begin
        rom_seen <= 1'b1;
      end
      if ((state == LOAD) && !ioctl_download && rom_seen) begin
        cfg_valid <= 1'b1;
      end
    end
  end

`ifdef DL_CHECKSUM_EN
  logic download_d;

  // The sum restarts on each download rise; a ROM byte strobed on that same
  // clock becomes the first term rather than being lost to the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      rom_sum    <= 8'd0;
      sum_valid  <= 1'b0;
      download_d <= 1'b0;
    end else begin
      download_d <= ioctl_download;
      if (ioctl_download && !download_d) begin
        rom_sum <= rom_hit ? ioctl_dout : 8'd0;
      end else if (rom_hit) begin
        rom_sum <= rom_sum + ioctl_dout;
      end
      if ((state == LOAD) && (state_next == SETTLE)) begin
        sum_valid <= 1'b1;
      end else if (state_next == LOAD) begin
        sum_valid <= 1'b0;
      end
    end
  end
`endif

endmodule
